// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch stage and its pending-write scoreboard.
package operand_fetch_pkg;
  localparam int D_DEF    = 8;
  localparam int I_DEF    = 4;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/operand_fetch_if.sv
// Bundles the upstream, RegisterFile, writeback and execute-side signals of operand_fetch.
// Handshake: a transfer happens on a posedge where valid && ready; valid never waits on ready, and held payload stays stable while valid && !ready.
interface operand_fetch_if #(
  parameter int D = 8,
  parameter int I = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [I-1:0]   in_src1_id;
  logic [I-1:0]   in_src2_id;
  logic [I-1:0]   in_dst_id;
  logic           in_wr;
  logic [I-1:0]   rf_src1_id;
  logic [I-1:0]   rf_src2_id;
  logic [D-1:0]   rf_src1_data;
  logic [D-1:0]   rf_src2_data;
  logic           wb_en;
  logic [I-1:0]   wb_id;
  logic [D-1:0]   wb_data;
  logic           out_valid;
  logic           out_ready;
  logic [D-1:0]   out_src1;
  logic [D-1:0]   out_src2;
  logic [I-1:0]   out_dst_id;
  logic           out_wr;
  logic [2**I-1:0] dbg_pending;

  modport slave (
    input  in_valid, in_src1_id, in_src2_id, in_dst_id, in_wr,
    input  rf_src1_data, rf_src2_data,
    input  wb_en, wb_id, wb_data,
    input  out_ready,
    output in_ready, rf_src1_id, rf_src2_id,
    output out_valid, out_src1, out_src2, out_dst_id, out_wr,
    output dbg_pending
  );

  modport master (
    output in_valid, in_src1_id, in_src2_id, in_dst_id, in_wr,
    output rf_src1_data, rf_src2_data,
    output wb_en, wb_id, wb_data,
    output out_ready,
    input  in_ready, rf_src1_id, rf_src2_id,
    input  out_valid, out_src1, out_src2, out_dst_id, out_wr,
    input  dbg_pending
  );
endinterface

// File: rtl/operand_fetch_op_scoreboard.sv
// Per-register pending-write bits plus RAW/WAW hazard detection against in-flight writes.
module op_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int I = I_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_set_en,
  input  logic [I-1:0]    i_set_id,
  input  logic            i_clr_en,
  input  logic [I-1:0]    i_clr_id,
  input  logic            i_valid,
  input  logic            i_wr,
  input  logic [I-1:0]    i_src1_id,
  input  logic [I-1:0]    i_src2_id,
  input  logic [I-1:0]    i_dst_id,
  output logic            o_hazard,
  output logic [2**I-1:0] o_pending
);
  localparam int N = 2**I;

  logic [N-1:0] r_pending;
  logic [N-1:0] w_eff_pend;
  logic [N-1:0] w_next;

  // A writeback landing this cycle already resolves its register, so it is masked out of the query.
  always_comb begin
    w_eff_pend = r_pending;
    if (i_clr_en) w_eff_pend[i_clr_id] = 1'b0;
    w_eff_pend[REG_ZERO] = 1'b0;
  end

  // Set is applied after clear so a same-id set/clear leaves the bit pending.
  always_comb begin
    w_next = w_eff_pend;
    if (i_set_en && (i_set_id != I'(REG_ZERO))) w_next[i_set_id] = 1'b1;
  end

  assign o_hazard = i_valid && (w_eff_pend[i_src1_id] || w_eff_pend[i_src2_id] ||
                                (i_wr && w_eff_pend[i_dst_id]));

  always_ff @(posedge clk) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_next;
  end

  assign o_pending = r_pending;
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch front end: RegisterFile read ports, writeback bypass and a one-entry output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int I = I_DEF
) (
  input  logic clk,
  input  logic rst_n,
  operand_fetch_if.slave bus
);
  logic          w_hazard;
  logic          w_in_ready;
  logic          w_xfer;
  logic [D-1:0]  w_op1;
  logic [D-1:0]  w_op2;
  logic [2**I-1:0] w_pending;

  logic          r_out_valid;
  logic [D-1:0]  r_out_src1;
  logic [D-1:0]  r_out_src2;
  logic [I-1:0]  r_out_dst_id;
  logic          r_out_wr;

  op_scoreboard #(.I(I)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (w_xfer && bus.in_wr),
    .i_set_id  (bus.in_dst_id),
    .i_clr_en  (bus.wb_en),
    .i_clr_id  (bus.wb_id),
    .i_valid   (bus.in_valid),
    .i_wr      (bus.in_wr),
    .i_src1_id (bus.in_src1_id),
    .i_src2_id (bus.in_src2_id),
    .i_dst_id  (bus.in_dst_id),
    .o_hazard  (w_hazard),
    .o_pending (w_pending)
  );

  assign w_in_ready = rst_n && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_xfer     = bus.in_valid && w_in_ready;

  // RegisterFile returns the pre-write value on a same-cycle write, so writeback data is forwarded here.
  always_comb begin
    w_op1 = bus.rf_src1_data;
    if (bus.in_src1_id == I'(REG_ZERO))                 w_op1 = '0;
    else if (bus.wb_en && (bus.wb_id == bus.in_src1_id)) w_op1 = bus.wb_data;
    w_op2 = bus.rf_src2_data;
    if (bus.in_src2_id == I'(REG_ZERO))                 w_op2 = '0;
    else if (bus.wb_en && (bus.wb_id == bus.in_src2_id)) w_op2 = bus.wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_src1   <= '0;
      r_out_src2   <= '0;
      r_out_dst_id <= '0;
      r_out_wr     <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_src1   <= w_op1;
      r_out_src2   <= w_op2;
      r_out_dst_id <= bus.in_dst_id;
      r_out_wr     <= bus.in_wr;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.rf_src1_id  = bus.in_src1_id;
  assign bus.rf_src2_id  = bus.in_src2_id;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_src1    = r_out_src1;
  assign bus.out_src2    = r_out_src2;
  assign bus.out_dst_id  = r_out_dst_id;
  assign bus.out_wr      = r_out_wr;
  assign bus.dbg_pending = w_pending;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazards, bypass, backpressure, register zero and mid-run reset.
module tb_operand_fetch;
  logic clk;
  logic rst_n;
  logic [7:0] rf_mem [16];
  int n_cmp;
  int n_fail;

  operand_fetch_if #(.D(8), .I(4)) bus ();

  operand_fetch #(.D(8), .I(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RegisterFile model: asynchronous read of the current contents.
  assign bus.rf_src1_data = rf_mem[bus.rf_src1_id];
  assign bus.rf_src2_data = rf_mem[bus.rf_src2_id];

  task automatic tick();
    @(posedge clk);
    if (bus.wb_en && (bus.wb_id != 4'd0)) rf_mem[bus.wb_id] = bus.wb_data;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d, input logic w);
    bus.in_valid   = 1'b1;
    bus.in_src1_id = s1;
    bus.in_src2_id = s2;
    bus.in_dst_id  = d;
    bus.in_wr      = w;
  endtask

  task automatic wb(input logic en, input logic [3:0] id, input logic [7:0] data);
    bus.wb_en   = en;
    bus.wb_id   = id;
    bus.wb_data = data;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'hA0 + 8'(i);
    rf_mem[0] = 8'hFF;
    rf_mem[2] = 8'h2C;
    rf_mem[3] = 8'h11;
    rf_mem[5] = 8'h22;
    rf_mem[7] = 8'h33;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_src1_id = '0;
    bus.in_src2_id = '0;
    bus.in_dst_id  = '0;
    bus.in_wr      = 1'b0;
    bus.out_ready  = 1'b1;
    wb(1'b0, 4'd0, 8'h00);

    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_src1", 32'(bus.out_src1), 32'h00);
    check("rst_out_src2", 32'(bus.out_src2), 32'h00);
    check("rst_out_dst", 32'(bus.out_dst_id), 32'd0);
    check("rst_out_wr", 32'(bus.out_wr), 32'd0);
    check("rst_pending", 32'(bus.dbg_pending), 32'h0000);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #2 check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // No hazard: r3 + r5 -> r7
    issue(4'd3, 4'd5, 4'd7, 1'b1);
    #2;
    check("rf_src1_id", 32'(bus.rf_src1_id), 32'd3);
    check("rf_src2_id", 32'(bus.rf_src2_id), 32'd5);
    check("nohaz_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("nohaz_out_valid", 32'(bus.out_valid), 32'd1);
    check("nohaz_src1", 32'(bus.out_src1), 32'h11);
    check("nohaz_src2", 32'(bus.out_src2), 32'h22);
    check("nohaz_dst", 32'(bus.out_dst_id), 32'd7);
    check("nohaz_wr", 32'(bus.out_wr), 32'd1);
    check("nohaz_pending", 32'(bus.dbg_pending), 32'h0080);

    // RAW on r7, resolved by same-cycle writeback bypass
    issue(4'd7, 4'd3, 4'd8, 1'b1);
    #2 check("raw_stall0", 32'(bus.in_ready), 32'd0);
    tick();
    check("raw_drain_valid", 32'(bus.out_valid), 32'd0);
    check("raw_hold_src1", 32'(bus.out_src1), 32'h11);
    check("raw_stall1", 32'(bus.in_ready), 32'd0);
    wb(1'b1, 4'd7, 8'h5A);
    #2 check("raw_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wb(1'b0, 4'd0, 8'h00);
    check("raw_out_valid", 32'(bus.out_valid), 32'd1);
    check("raw_bypass_src1", 32'(bus.out_src1), 32'h5A);
    check("raw_src2", 32'(bus.out_src2), 32'h11);
    check("raw_dst", 32'(bus.out_dst_id), 32'd8);
    check("raw_pending", 32'(bus.dbg_pending), 32'h0100);

    // WAW on r4 with same-cycle set and clear
    issue(4'd0, 4'd0, 4'd4, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("waw_pre_pending", 32'(bus.dbg_pending), 32'h0110);
    issue(4'd3, 4'd5, 4'd4, 1'b1);
    wb(1'b1, 4'd4, 8'h44);
    #2 check("waw_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wb(1'b0, 4'd0, 8'h00);
    check("waw_pending", 32'(bus.dbg_pending), 32'h0110);
    check("waw_src1", 32'(bus.out_src1), 32'h11);
    check("waw_dst", 32'(bus.out_dst_id), 32'd4);

    // Drain pending bits; r9 was never pending
    wb(1'b1, 4'd8, 8'h88); tick();
    wb(1'b1, 4'd4, 8'h44); tick();
    wb(1'b1, 4'd9, 8'h99); tick();
    wb(1'b0, 4'd0, 8'h00);
    check("drain_pending", 32'(bus.dbg_pending), 32'h0000);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: A is held for 3 cycles while B waits
    bus.out_ready = 1'b0;
    issue(4'd3, 4'd5, 4'd1, 1'b0);
    #2 check("bp_a_ready", 32'(bus.in_ready), 32'd1);
    tick();
    issue(4'd5, 4'd3, 4'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #2 check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_src1", 32'(bus.out_src1), 32'h11);
      check("bp_src2", 32'(bus.out_src2), 32'h22);
      check("bp_dst", 32'(bus.out_dst_id), 32'd1);
    end
    bus.out_ready = 1'b1;
    #2 check("bp_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_b_valid", 32'(bus.out_valid), 32'd1);
    check("bp_b_src1", 32'(bus.out_src1), 32'h22);
    check("bp_b_src2", 32'(bus.out_src2), 32'h11);
    check("bp_b_dst", 32'(bus.out_dst_id), 32'd2);
    tick();
    check("bp_no_dup", 32'(bus.out_valid), 32'd0);
    check("bp_data_hold", 32'(bus.out_src1), 32'h22);

    // Register zero reads as 0 and never becomes pending
    issue(4'd0, 4'd0, 4'd0, 1'b1);
    wb(1'b1, 4'd0, 8'h77);
    #2 check("r0_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    wb(1'b0, 4'd0, 8'h00);
    check("r0_out_valid", 32'(bus.out_valid), 32'd1);
    check("r0_src1", 32'(bus.out_src1), 32'h00);
    check("r0_src2", 32'(bus.out_src2), 32'h00);
    check("r0_dst", 32'(bus.out_dst_id), 32'd0);
    check("r0_wr", 32'(bus.out_wr), 32'd1);
    check("r0_pending", 32'(bus.dbg_pending), 32'h0000);
    #2 check("r0_followup_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("r0_followup_valid", 32'(bus.out_valid), 32'd1);
    check("r0_followup_src1", 32'(bus.out_src1), 32'h00);

    // Reset mid-operation
    issue(4'd3, 4'd5, 4'd2, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("mid_pending", 32'(bus.dbg_pending), 32'h0004);
    check("mid_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    issue(4'd2, 4'd0, 4'd6, 1'b0);
    #2 check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_src1", 32'(bus.out_src1), 32'h00);
    check("mid_rst_src2", 32'(bus.out_src2), 32'h00);
    check("mid_rst_dst", 32'(bus.out_dst_id), 32'd0);
    check("mid_rst_wr", 32'(bus.out_wr), 32'd0);
    check("mid_rst_pending", 32'(bus.dbg_pending), 32'h0000);
    #2 check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_src1", 32'(bus.out_src1), 32'h2C);
    check("post_rst_src2", 32'(bus.out_src2), 32'h00);
    check("post_rst_dst", 32'(bus.out_dst_id), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Consumer-side front end of RegisterFile: drives the two read ports (src1_id/src2_id) and registers the returned operands into a one-entry skid-free pipeline register toward execute.
- Holds a per-register pending scoreboard. Stalls on read-after-write (RAW) and write-after-write (WAW) hazards against in-flight writes.
- Bypasses same-cycle writeback data, because RegisterFile write-then-read in one cycle returns the old value.

Parameters:
- D, 8, operand/data width (matches RegisterFile D)
- I, 4, register index width; 2**I registers, index 0 hardwired zero

Ports:
- clk  input  1  single clock, all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  upstream may transfer this cycle
- in_src1_id  input  I  first source register
- in_src2_id  input  I  second source register
- in_dst_id  input  I  destination register
- in_wr  input  1  instruction writes in_dst_id
- rf_src1_id  output  I  to RegisterFile src1_id
- rf_src2_id  output  I  to RegisterFile src2_id
- rf_src1_data  input  D  from RegisterFile src1_out
- rf_src2_data  input  D  from RegisterFile src2_out
- wb_en  input  1  writeback this cycle (same signal as RegisterFile wr_en)
- wb_id  input  I  writeback register
- wb_data  input  D  writeback value
- out_valid  output  1  operands valid to execute
- out_ready  input  1  execute accepts
- out_src1  output  D  operand 1
- out_src2  output  D  operand 2
- out_dst_id  output  I  destination passthrough
- out_wr  output  1  write flag passthrough

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_src1=0, out_src2=0, out_dst_id=0, out_wr=0, all pending bits=0. Reset mid-operation drops any held instruction and clears the scoreboard; in_ready is held 0 while rst_n=0.
- rf_srcN_id = in_srcN_id, combinational, with no register between.
- Effective pending: eff_pend[r] = pending[r] && !(wb_en && wb_id==r). Register 0 is never pending.
- Hazard: in_valid && (eff_pend[in_src1_id] || eff_pend[in_src2_id] || (in_wr && eff_pend[in_dst_id])).
- in_ready = rst_n && !hazard && (!out_valid || out_ready).
- Transfer (in_valid && in_ready), registered one cycle later:
  - out_valid=1; out_dst_id and out_wr take the incoming values.
  - out_srcN = 0 if in_srcN_id==0.
  - Otherwise out_srcN = wb_data if wb_en && wb_id==in_srcN_id.
  - Otherwise out_srcN = rf_srcN_data.
- No transfer and out_ready=1: out_valid clears. Output data holds its value.
- out_valid=1 and out_ready=0: all outputs hold stable.
- Latency: 1 cycle from transfer to out_valid. Throughput is 1 per cycle with no hazards.
- Scoreboard update each posedge:
  - pending[wb_id] clears when wb_en.
  - pending[in_dst_id] sets on a transfer with in_wr=1 and in_dst_id!=0.
  - Same id set and cleared in one cycle: the set wins, giving final pending=1.
  - wb_en to a non-pending register is legal and leaves it at 0.
  - wb_en with wb_id=0 has no effect.
- Writes to register 0 never create hazards and never set pending.

Decomposition:
- Shared package: D/I defaults, REG_ZERO index constant.
- Natural sub-module: op_scoreboard. It holds the 2**I pending bits with set/clear/eff_pend query ports, and owns the hazard logic.
- operand_fetch keeps the handshake, bypass muxes and output register.

Test Plan:
- No hazards (D=8, I=4): r3=0x11, r5=0x22 preloaded, issue src1=3, src2=5, dst=7, wr=1 with out_ready=1 -> next cycle out_valid=1, out_src1=0x11, out_src2=0x22, out_dst_id=7; pending[7]=1.
- RAW stall: after the above, issue src1=7 -> in_ready=0 until the cycle with wb_en=1, wb_id=7, wb_data=0x5A. In that cycle transfer occurs and out_src1=0x5A via bypass, not the stale RF value.
- WAW with same-cycle set/clear: pending[4]=1, issue dst=4, wr=1 together with wb_en, wb_id=4 -> transfer accepted, pending[4]=1 afterward.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and outputs unchanged. Then out_ready=1 -> the next queued instruction appears 1 cycle later with no drop or duplicate.
- Register 0: issue src1=0, src2=0, dst=0, wr=1 while RF returns 0xFF -> out_src1=0, out_src2=0, no pending set. An immediate follow-up reading r0 does not stall.
- Reset mid-operation: pending[2]=1, out_valid=1, assert rst_n=0 for one cycle -> out_valid=0 and all outputs 0. Then issue src1=2 -> no stall.
